// File: rtl/pinmux_ctrl.sv
// Purpose: runtime pad multiplexer. OUTSEL picks an output source per pad, INSEL picks a pad per peripheral input.
// Latency: reg response 1 cycle; OUTSEL change visible GuardCycles+1 cycles after the write; pad->periph_in 2 cycles.
// Backpressure: none; every request is answered. OUTSEL writes are refused with err while a guard is running.
//
// Ports: clk_i/rst_ni clock and async active-low reset; reg_* simple register bus (req/we/addr/wdata in,
// rvalid/rdata/err out); periph_out_i/periph_oe_i per-source output values; periph_in_o per-peripheral input;
// pad_out_o/pad_oe_o/pad_in_i padring side; busy_o high while a break-before-make guard is in progress.
module pinmux_ctrl #(
    parameter int NPads       = 64,
    parameter int NOutSel     = 16,
    parameter int NPeriphIn   = 16,
    parameter int GuardCycles = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 reg_req_i,
    input  logic                 reg_we_i,
    input  logic [7:0]           reg_addr_i,
    input  logic [31:0]          reg_wdata_i,
    output logic                 reg_rvalid_o,
    output logic [31:0]          reg_rdata_o,
    output logic                 reg_err_o,
    input  logic [NOutSel-1:0]   periph_out_i,
    input  logic [NOutSel-1:0]   periph_oe_i,
    output logic [NPeriphIn-1:0] periph_in_o,
    output logic [NPads-1:0]     pad_out_o,
    output logic [NPads-1:0]     pad_oe_o,
    input  logic [NPads-1:0]     pad_in_i,
    output logic                 busy_o
);

    localparam int SelW = $clog2(NOutSel);
    localparam int PadW = $clog2(NPads);
    localparam int InW  = $clog2(NPeriphIn);
    localparam int CntW = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;

    localparam logic [7:0]      InselBase  = 8'h40;
    localparam logic [7:0]      InselEnd   = 8'(64 + NPeriphIn);
    localparam logic [7:0]      OutselEnd  = 8'(NPads);
    localparam logic [7:0]      StatusIdx  = 8'h80;
    localparam logic [7:0]      LockIdx    = 8'h81;
    localparam logic [31:0]     NOutSelW   = 32'(NOutSel);
    localparam logic [6:0]      NPadsW     = 7'(NPads);
    localparam logic [CntW-1:0] CntInit    = CntW'(GuardCycles - 1);

    typedef enum logic {IDLE, GUARD} state_t;

    state_t                         state_q;
    logic                           busy_q;
    logic [CntW-1:0]                cnt_q;
    logic [PadW-1:0]                pend_pad_q;
    logic [SelW-1:0]                pend_val_q;
    logic [NPads-1:0][SelW-1:0]     outsel_q;
    logic [NPeriphIn-1:0][6:0]      insel_q;
    logic                           locked_q;
    logic [NPads-1:0]               sync1_q;
    logic [NPads-1:0]               sync2_q;
    logic                           rvalid_q;
    logic                           err_q;
    logic [31:0]                    rdata_q;

    // Register decode
    logic            is_outsel;
    logic            is_insel;
    logic [PadW-1:0] a_pad;
    logic [InW-1:0]  a_in;
    logic            rsp_err_d;
    logic [31:0]     rsp_rdata_d;
    logic            outsel_start;
    logic            insel_we;
    logic            lock_set;

    assign is_outsel = (reg_addr_i < OutselEnd);
    assign is_insel  = (reg_addr_i >= InselBase) && (reg_addr_i < InselEnd);
    assign a_pad     = reg_addr_i[PadW-1:0];
    assign a_in      = reg_addr_i[InW-1:0];

    always_comb begin
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;
        outsel_start = 1'b0;
        insel_we     = 1'b0;
        lock_set     = 1'b0;
        if (reg_req_i) begin
            if (is_outsel) begin
                if (reg_we_i) begin
                    // busy_q is the registered guard flag, so a write landing on the
                    // completion cycle still sees busy and is refused.
                    if (locked_q || busy_q || (reg_wdata_i >= NOutSelW)) begin
                        rsp_err_d = 1'b1;
                    end else if (reg_wdata_i[SelW-1:0] != outsel_q[a_pad]) begin
                        outsel_start = 1'b1;
                    end
                end else begin
                    rsp_rdata_d = 32'(outsel_q[a_pad]);
                end
            end else if (is_insel) begin
                if (reg_we_i) begin
                    if (locked_q) rsp_err_d = 1'b1;
                    else          insel_we  = 1'b1;
                end else begin
                    rsp_rdata_d = 32'(insel_q[a_in]);
                end
            end else if (reg_addr_i == StatusIdx) begin
                if (reg_we_i) rsp_err_d   = 1'b1;
                else          rsp_rdata_d = {30'd0, locked_q, busy_q};
            end else if (reg_addr_i == LockIdx) begin
                if (reg_we_i) begin
                    if (locked_q) rsp_err_d = 1'b1;
                    else          lock_set  = reg_wdata_i[0];
                end else begin
                    rsp_rdata_d = {31'd0, locked_q};
                end
            end else begin
                rsp_err_d = 1'b1;
            end
        end
    end

    // Break-before-make FSM: one pending OUTSEL change held in pend_*_q until the
    // guard count expires; only then is the committed OUTSEL updated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            pend_pad_q <= '0;
            pend_val_q <= '0;
            outsel_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (outsel_start) begin
                        pend_pad_q <= a_pad;
                        pend_val_q <= reg_wdata_i[SelW-1:0];
                        cnt_q      <= CntInit;
                        state_q    <= GUARD;
                        busy_q     <= 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt_q == '0) begin
                        outsel_q[pend_pad_q] <= pend_val_q;
                        state_q              <= IDLE;
                        busy_q               <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            insel_q  <= '1;
            locked_q <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (insel_we) insel_q[a_in] <= reg_wdata_i[6:0];
            if (lock_set) locked_q      <= 1'b1;
            rvalid_q <= reg_req_i;
            err_q    <= rsp_err_d;
            rdata_q  <= rsp_rdata_d;
        end
    end

    // Pad inputs are asynchronous to clk_i; reset high to match the idle-high default.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= pad_in_i;
            sync2_q <= sync1_q;
        end
    end

    // Output mux; the pad under guard is held hi-Z regardless of its committed source.
    always_comb begin
        logic [SelW-1:0] sel;
        sel       = '0;
        pad_out_o = '0;
        pad_oe_o  = '0;
        for (int p = 0; p < NPads; p++) begin
            sel = outsel_q[p];
            if (!(busy_q && (pend_pad_q == PadW'(p))) && (sel != '0)) begin
                pad_out_o[p] = periph_out_i[sel];
                pad_oe_o[p]  = periph_oe_i[sel];
            end
        end
    end

    // Input mux; out-of-range INSEL values read as idle-high.
    always_comb begin
        logic [6:0] isel;
        isel        = '0;
        periph_in_o = '1;
        for (int k = 0; k < NPeriphIn; k++) begin
            isel = insel_q[k];
            if (isel < NPadsW) periph_in_o[k] = sync2_q[isel[PadW-1:0]];
        end
    end

    assign reg_rvalid_o = rvalid_q;
    assign reg_err_o    = err_q;
    assign reg_rdata_o  = rdata_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_pinmux_ctrl.sv
// Purpose: self-checking bench for pinmux_ctrl; register responses go through a scoreboard queue.
// Latency: expected responses are pushed when a request is driven and popped on reg_rvalid_o.
// Backpressure: none; the bench issues at most one request per cycle.
module tb_pinmux_ctrl;

    logic        clk_i;
    logic        rst_ni;
    logic        reg_req_i;
    logic        reg_we_i;
    logic [7:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic        reg_rvalid_o;
    logic [31:0] reg_rdata_o;
    logic        reg_err_o;
    logic [15:0] periph_out_i;
    logic [15:0] periph_oe_i;
    logic [15:0] periph_in_o;
    logic [63:0] pad_out_o;
    logic [63:0] pad_oe_o;
    logic [63:0] pad_in_i;
    logic        busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [32:0] exp_q[$];
    string       tag_q[$];

    pinmux_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .reg_req_i    (reg_req_i),
        .reg_we_i     (reg_we_i),
        .reg_addr_i   (reg_addr_i),
        .reg_wdata_i  (reg_wdata_i),
        .reg_rvalid_o (reg_rvalid_o),
        .reg_rdata_o  (reg_rdata_o),
        .reg_err_o    (reg_err_o),
        .periph_out_i (periph_out_i),
        .periph_oe_i  (periph_oe_i),
        .periph_in_o  (periph_in_o),
        .pad_out_o    (pad_out_o),
        .pad_oe_o     (pad_oe_o),
        .pad_in_i     (pad_in_i),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge; drives one request for one cycle and returns at the next negedge.
    task automatic reg_acc(input string tag, input logic we, input logic [7:0] a,
                           input logic [31:0] wd, input logic er, input logic [31:0] rd);
        reg_req_i   = 1'b1;
        reg_we_i    = we;
        reg_addr_i  = a;
        reg_wdata_i = wd;
        exp_q.push_back({er, rd});
        tag_q.push_back(tag);
        @(negedge clk_i);
        reg_req_i   = 1'b0;
        reg_we_i    = 1'b0;
        reg_wdata_i = '0;
    endtask

    always @(negedge clk_i) begin
        if (reg_rvalid_o) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                logic [32:0] e;
                string       t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, {31'd0, reg_err_o, reg_rdata_o}, {31'd0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni       = 1'b0;
        reg_req_i    = 1'b0;
        reg_we_i     = 1'b0;
        reg_addr_i   = '0;
        reg_wdata_i  = '0;
        periph_out_i = 16'h0008;  // source 3 drives 1, source 4 drives 0
        periph_oe_i  = 16'h0018;  // sources 3 and 4 enabled
        pad_in_i     = '0;
        repeat (3) @(negedge clk_i);
        check("rst_rvalid", reg_rvalid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_pad_oe", pad_oe_o, 0);
        check("rst_periph_in", periph_in_o, 16'hFFFF);
        rst_ni = 1'b1;
        @(negedge clk_i);

        reg_acc("rd_outsel5", 0, 8'd5, 0, 0, 0);

        // First assignment: pad 34 from disabled to source 3.
        reg_acc("wr_os34_3", 1, 8'd34, 3, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            check("guard1_oe34", pad_oe_o[34], 0);
            check("guard1_busy", busy_o, 1);
            @(negedge clk_i);
        end
        check("new1_oe34", pad_oe_o[34], 1);
        check("new1_out34", pad_out_o[34], 1);
        check("new1_busy", busy_o, 0);

        // Re-assignment 3 -> 4: old source has oe=1, so the guard must force hi-Z.
        reg_acc("wr_os34_4", 1, 8'd34, 4, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            check("guard2_oe34", pad_oe_o[34], 0);
            @(negedge clk_i);
        end
        check("new2_oe34", pad_oe_o[34], 1);
        check("new2_out34", pad_out_o[34], 0);

        // Write during busy is refused.
        reg_acc("wr_os10_5", 1, 8'd10, 5, 0, 0);
        reg_acc("wr_os10_busy", 1, 8'd10, 6, 1, 0);
        repeat (3) @(negedge clk_i);
        reg_acc("rd_os10", 0, 8'd10, 0, 0, 5);

        // Write on the completion cycle is refused too.
        reg_acc("wr_os11_2", 1, 8'd11, 2, 0, 0);
        repeat (3) @(negedge clk_i);
        reg_acc("wr_os11_last", 1, 8'd11, 7, 1, 0);
        check("done_busy", busy_o, 0);
        reg_acc("rd_os11", 0, 8'd11, 0, 0, 2);

        // Same value: no guard.
        reg_acc("wr_os11_same", 1, 8'd11, 2, 0, 0);
        check("same_busy", busy_o, 0);

        reg_acc("wr_os0_range", 1, 8'd0, 16, 1, 0);
        reg_acc("rd_unmapped", 0, 8'h90, 0, 1, 0);
        reg_acc("wr_status", 1, 8'h80, 3, 1, 0);
        reg_acc("rd_os0", 0, 8'd0, 0, 0, 0);

        // INSEL path with synchroniser latency.
        reg_acc("wr_in2_59", 1, 8'h42, 59, 0, 0);
        check("in2_low", periph_in_o[2], 0);
        reg_acc("rd_in2", 0, 8'h42, 0, 0, 59);
        pad_in_i[59] = 1'b1;
        @(negedge clk_i);
        check("in2_sync1", periph_in_o[2], 0);
        @(negedge clk_i);
        check("in2_sync2", periph_in_o[2], 1);
        pad_in_i[59] = 1'b0;
        repeat (2) @(negedge clk_i);
        check("in2_fall", periph_in_o[2], 0);
        reg_acc("wr_in2_100", 1, 8'h42, 100, 0, 0);
        check("in2_idle_hi", periph_in_o[2], 1);

        // LOCK set while a guard runs: the guard still completes.
        reg_acc("wr_os7_9", 1, 8'd7, 9, 0, 0);
        reg_acc("wr_lock", 1, 8'h81, 1, 0, 0);
        reg_acc("rd_status_lb", 0, 8'h80, 0, 0, 3);
        repeat (2) @(negedge clk_i);
        reg_acc("rd_os7", 0, 8'd7, 0, 0, 9);
        reg_acc("rd_status_l", 0, 8'h80, 0, 0, 2);
        reg_acc("wr_os1_locked", 1, 8'd1, 1, 1, 0);
        reg_acc("wr_in0_locked", 1, 8'h40, 3, 1, 0);
        reg_acc("wr_lock_locked", 1, 8'h81, 1, 1, 0);
        reg_acc("rd_os1", 0, 8'd1, 0, 0, 0);
        reg_acc("rd_in0", 0, 8'h40, 0, 0, 32'h7F);
        reg_acc("rd_in2_l", 0, 8'h42, 0, 0, 100);
        reg_acc("rd_lock", 0, 8'h81, 0, 0, 1);

        // Reset during a guard discards the pending change.
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        reg_acc("wr_os20_1", 1, 8'd20, 1, 0, 0);
        check("mid_busy", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_rvalid", reg_rvalid_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        reg_acc("rd_os20", 0, 8'd20, 0, 0, 0);
        reg_acc("rd_status_rst", 0, 8'h80, 0, 0, 0);
        repeat (6) @(negedge clk_i);
        check("post_busy", busy_o, 0);

        repeat (2) @(negedge clk_i);
        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
